// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for the RV32M iterative divider.
//   div_state_t    - controller states IDLE / CALC / DONE
//   F3_*           - funct3 encodings of DIV, DIVU, REM, REMU
//   DIV_ITERATIONS - quotient bits produced, one per CALC cycle
//   neg_if()       - conditional two's-complement negate used by the sign fix-up
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam int DIV_ITERATIONS = 32;

    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/divider_step.sv
// div_step: one radix-2 restoring division iteration (purely combinational).
//   rem, quo  - partial remainder and dividend/quotient shift register
//   divisor   - unsigned divisor magnitude
//   rem_next, quo_next - state after shifting in one dividend bit and
//                        committing one quotient bit
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;
    logic          borrow;
    logic          accept;
    logic [XLEN:0] rem_w;
    logic          unused_rem_top;

    // {rem, quo} << 1: the dividend MSB moves into the remainder.
    assign rem_sh = {rem, quo[XLEN-1]};
    // 33-bit trial subtract; the extra borrow bit is the sign of the trial.
    assign {borrow, trial} = {1'b0, rem_sh} - {2'b00, divisor};
    assign accept = ~borrow;
    assign rem_w  = accept ? trial : rem_sh;
    // The remainder stays below the divisor, so bit XLEN is always zero here.
    assign unused_rem_top = rem_w[XLEN];
    assign rem_next = rem_w[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], accept};

endmodule

// File: rtl/divider.sv
// divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset
//   ce      - start request (only honoured in IDLE with funct3[2]=1)
//   funct3  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a, b    - dividend (rs1), divisor (rs2)
//   result  - registered quotient/remainder, updated only on entry to DONE
//   stall   - high while an operation is in flight (combinational)
// Configuration:
//   DIVIDER_EARLY_OUT_EN - when defined, divide-by-zero and signed overflow
//   skip CALC and go IDLE -> DONE. Results are the same either way.
module divider
    import divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    localparam int CNT_W = $clog2(DIV_ITERATIONS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERATIONS - 1);
    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};

    div_state_t      state;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, divisor_q, a_q;
    logic            is_rem_q, neg_q, neg_r, div0_q, ovf_q;

    // start-of-operation decode from the live inputs
    logic            start;
    logic            is_signed, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] a_abs, b_abs;

    assign start     = (state == IDLE) && ce && funct3[2];
    assign is_signed = ~funct3[0];
    assign a_neg     = is_signed & a[XLEN-1];
    assign b_neg     = is_signed & b[XLEN-1];
    assign a_abs     = a_neg ? (~a + 1'b1) : a;
    assign b_abs     = b_neg ? (~b + 1'b1) : b;
    assign div0      = (b == '0);
    assign ovf       = is_signed && (a == SMIN) && (b == ONES);

    assign stall = start || (state == CALC);

    // datapath iteration
    logic [XLEN-1:0] step_rem, step_quo;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // final sign fix-up plus special-case override, evaluated on the last
    // iteration so result is loaded as DONE is entered
    logic [XLEN-1:0] q_fin, r_fin, result_calc;

    always_comb begin
        q_fin = neg_if(neg_q, step_quo);
        r_fin = neg_if(neg_r, step_rem);
        if (div0_q) begin
            q_fin = ONES;
            r_fin = a_q;
        end else if (ovf_q) begin
            q_fin = SMIN;
            r_fin = '0;
        end
        result_calc = is_rem_q ? r_fin : q_fin;
    end

`ifdef DIVIDER_EARLY_OUT_EN
    logic            early;
    logic [XLEN-1:0] early_val;

    always_comb begin
        early     = div0 || ovf;
        early_val = ONES;
        if (div0)
            early_val = funct3[1] ? a : ONES;
        else if (ovf)
            early_val = funct3[1] ? '0 : SMIN;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            a_q       <= '0;
            is_rem_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_rem_q  <= funct3[1];
                        neg_q     <= a_neg ^ b_neg;
                        neg_r     <= a_neg;
                        div0_q    <= div0;
                        ovf_q     <= ovf;
                        a_q       <= a;
                        divisor_q <= b_abs;
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
`ifdef DIVIDER_EARLY_OUT_EN
                        if (early) begin
                            result <= early_val;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
`else
                        state     <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result <= result_calc;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed self-checking bench for the divider.
module tb_divider;
    import divider_pkg::*;

`ifdef DIVIDER_EARLY_OUT_EN
    localparam int EO_STALL = 1;
`else
    localparam int EO_STALL = 33;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic [31:0] result;
    logic        stall;

    int errors = 0;
    int checks = 0;
    logic [31:0] last = 32'd0;

    divider #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .result (result),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start one op, count stall cycles, check result in the DONE cycle and
    // that result held its previous value while busy.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ex, input bit special, input string tag);
        int n;
        int hold_bad;
        int exp_n;
        exp_n = special ? EO_STALL : 33;
        @(posedge clk); #1;
        ce = 1'b1; funct3 = f3; a = av; b = bv;
        n = 0; hold_bad = 0;
        @(negedge clk);
        while (stall && n < 40) begin
            n++;
            if (result !== last) hold_bad++;
            @(posedge clk); #1;
            ce = 1'b0;
            @(negedge clk);
        end
        ce = 1'b0;
        chk({tag, " stall_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, " result"}, result, ex);
        chk({tag, " hold"}, 32'(hold_bad), 32'd0);
        last = ex;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; funct3 = 3'b000; a = '0; b = '0;
        #1;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset result", result, 32'd0);
        #11 reset = 1'b0;

        // non-divide funct3 never starts
        @(posedge clk); #1;
        ce = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'd3;
        @(negedge clk);
        chk("f3_000 stall T", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("f3_000 stall T+1", {31'd0, stall}, 32'd0);
        ce = 1'b0;

        run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu 100/7");
        run_op(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b0, "remu 100/7");
        run_op(F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, "div -7/2");
        run_op(F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, "rem -7/2");
        run_op(F3_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div 7/-2");
        run_op(F3_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, "rem 7/-2");
        run_op(F3_DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2, 1'b0, "div -8/-3");
        run_op(F3_REM, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, "rem -8/-3");
        run_op(F3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, "divu 5/0");
        run_op(F3_REMU, 32'd5, 32'd0, 32'd5, 1'b1, "remu 5/0");
        run_op(F3_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1'b1, "div -5/0");
        run_op(F3_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1'b1, "rem -5/0");
        run_op(F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div ovf");
        run_op(F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, "rem ovf");
        run_op(F3_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, "divu big");
        run_op(F3_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "remu big");

        // ce held high; operands change at T+10 and must be ignored
        @(posedge clk); #1;
        ce = 1'b1; funct3 = F3_DIVU; a = 32'd100; b = 32'd7;
        repeat (10) @(posedge clk);
        #1; a = 32'd1000; b = 32'd9;
        repeat (23) @(posedge clk);
        @(negedge clk);
        chk("held ce DONE stall", {31'd0, stall}, 32'd0);
        chk("held ce result", result, 32'd14);
        // T+34: back to IDLE with ce still high starts the next divide
        @(negedge clk);
        chk("b2b start stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1; ce = 1'b0;
        repeat (32) @(posedge clk);
        @(negedge clk);
        chk("b2b DONE stall", {31'd0, stall}, 32'd0);
        chk("b2b result", result, 32'd111);
        last = 32'd111;

        // asynchronous reset mid-operation
        @(posedge clk); #1;
        ce = 1'b1; funct3 = F3_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1; ce = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("pre-reset stall", {31'd0, stall}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset stall", {31'd0, stall}, 32'd0);
        chk("async reset result", result, 32'd0);
        #2 reset = 1'b0;
        last = 32'd0;
        run_op(F3_DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, 1'b0, "divu ffffffff/3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
